// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter.
// Merges the in-order pipeline writeback with results from a long-latency
// unit. Long-latency results wait in a small FIFO. The pipeline always wins
// the write port. The FIFO head drains when the port is free, or is dropped
// when it is dead: it targets register 0, or a same-edge pipeline write to
// the same register supersedes it.
module wb_arbiter #(
    parameter int W     = 32,
    parameter int A     = 5,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         pipe_valid,
    input  logic [A-1:0] pipe_reg,
    input  logic [W-1:0] pipe_data,
    input  logic         mdu_valid,
    output logic         mdu_ready,
    input  logic [A-1:0] mdu_reg,
    input  logic [W-1:0] mdu_data,
    input  logic [A-1:0] chk_reg,
    output logic         chk_hit,
    output logic         w,
    output logic [A-1:0] W_Reg,
    output logic [W-1:0] W_Data,
    output logic         pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // FIFO storage and bookkeeping
    logic [A-1:0]  reg_mem_q  [DEPTH];
    logic [W-1:0]  data_mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Registered write port
    logic          w_q, w_d;
    logic [A-1:0]  wreg_q, wreg_d;
    logic [W-1:0]  wdata_q, wdata_d;

    // Per-edge decisions
    logic          pipe_sel_s;
    logic          head_valid_s;
    logic [A-1:0]  head_reg_s;
    logic [W-1:0]  head_data_s;
    logic          push_s;
    logic          pop_s;
    logic          head_wr_s;
    logic          ready_s;
    logic          hit_s;
    logic [PW-1:0] chk_idx_s;

    // Acceptance depends only on the registered count, so a full buffer
    // never accepts in the same cycle that its head pops.
    assign ready_s   = (count_q < DEPTH_C);
    assign mdu_ready = ready_s;
    assign pending   = (count_q != {CW{1'b0}});
    assign w         = w_q;
    assign W_Reg     = wreg_q;
    assign W_Data    = wdata_q;
    assign chk_hit   = hit_s;

    // Arbitration: choose the writer, decide pop/push, compute next state
    always_comb begin
        pipe_sel_s   = pipe_valid && (pipe_reg != {A{1'b0}});
        head_valid_s = (count_q != {CW{1'b0}});
        head_reg_s   = reg_mem_q[rd_ptr_q];
        head_data_s  = data_mem_q[rd_ptr_q];
        push_s       = mdu_valid && ready_s;
        pop_s        = 1'b0;
        head_wr_s    = 1'b0;

        if (head_valid_s) begin
            if (head_reg_s == {A{1'b0}}) begin
                // Result for register 0 is discarded without a write
                pop_s = 1'b1;
            end else if (!pipe_sel_s) begin
                pop_s     = 1'b1;
                head_wr_s = 1'b1;
            end else if (head_reg_s == pipe_reg) begin
                // Same-edge pipeline write to the same register is younger
                pop_s = 1'b1;
            end else begin
                pop_s = 1'b0;
            end
        end else begin
            pop_s = 1'b0;
        end

        if (pipe_sel_s) begin
            w_d     = 1'b1;
            wreg_d  = pipe_reg;
            wdata_d = pipe_data;
        end else if (head_wr_s) begin
            w_d     = 1'b1;
            wreg_d  = head_reg_s;
            wdata_d = head_data_s;
        end else begin
            w_d     = 1'b0;
            wreg_d  = wreg_q;
            wdata_d = wdata_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
            2'b01:   count_d = count_q - {{(CW-1){1'b0}}, 1'b1};
            default: count_d = count_q;
        endcase

        if (push_s) begin
            wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
    end

    // Hazard lookup over the live entries, including a head popping this cycle
    always_comb begin
        hit_s     = 1'b0;
        chk_idx_s = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) begin
            chk_idx_s = rd_ptr_q + PW'(i);
            if ((CW'(i) < count_q) && (reg_mem_q[chk_idx_s] == chk_reg) &&
                (chk_reg != {A{1'b0}})) begin
                hit_s = 1'b1;
            end else begin
                hit_s = hit_s;
            end
        end
    end

    // Control state and registered write port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q  <= {CW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            wr_ptr_q <= {PW{1'b0}};
            w_q      <= 1'b0;
            wreg_q   <= {A{1'b0}};
            wdata_q  <= {W{1'b0}};
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            w_q      <= w_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
        end
    end

    // FIFO entry storage, written at the tail on an accepted offer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                reg_mem_q[i]  <= {A{1'b0}};
                data_mem_q[i] <= {W{1'b0}};
            end
        end else if (push_s) begin
            reg_mem_q[wr_ptr_q]  <= mdu_reg;
            data_mem_q[wr_ptr_q] <= mdu_data;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.
module tb_wb_arbiter;

    localparam int W     = 32;
    localparam int A     = 5;
    localparam int DEPTH = 2;

    logic         clk;
    logic         rst;
    logic         pipe_valid;
    logic [A-1:0] pipe_reg;
    logic [W-1:0] pipe_data;
    logic         mdu_valid;
    logic         mdu_ready;
    logic [A-1:0] mdu_reg;
    logic [W-1:0] mdu_data;
    logic [A-1:0] chk_reg;
    logic         chk_hit;
    logic         w;
    logic [A-1:0] W_Reg;
    logic [W-1:0] W_Data;
    logic         pending;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: buffered results in arrival order, and expected port
    logic [A-1:0] mq_reg  [$];
    logic [W-1:0] mq_data [$];
    logic         exp_w;
    logic [A-1:0] exp_wreg;
    logic [W-1:0] exp_wdata;

    wb_arbiter #(.W(W), .A(A), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .pipe_valid (pipe_valid),
        .pipe_reg   (pipe_reg),
        .pipe_data  (pipe_data),
        .mdu_valid  (mdu_valid),
        .mdu_ready  (mdu_ready),
        .mdu_reg    (mdu_reg),
        .mdu_data   (mdu_data),
        .chk_reg    (chk_reg),
        .chk_hit    (chk_hit),
        .w          (w),
        .W_Reg      (W_Reg),
        .W_Data     (W_Data),
        .pending    (pending)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_hit(input logic [A-1:0] c);
        if (c == 0) return 1'b0;
        foreach (mq_reg[i]) if (mq_reg[i] == c) return 1'b1;
        return 1'b0;
    endfunction

    // One clock: drive inputs, check combinational outputs, step model on
    // the edge, then check the registered write port.
    task automatic cycle(input logic pv, input logic [A-1:0] pr, input logic [W-1:0] pd,
                         input logic mv, input logic [A-1:0] mr, input logic [W-1:0] md,
                         input logic [A-1:0] cr);
        logic         ready;
        logic         psel;
        logic         head_write;
        logic [A-1:0] hr;
        logic [W-1:0] hd;
        pipe_valid = pv; pipe_reg = pr; pipe_data = pd;
        mdu_valid  = mv; mdu_reg  = mr; mdu_data  = md;
        chk_reg    = cr;
        #1;
        chk("mdu_ready", mdu_ready, mq_reg.size() < DEPTH);
        chk("pending", pending, mq_reg.size() != 0);
        chk("chk_hit", chk_hit, model_hit(cr));
        @(posedge clk);
        ready      = (mq_reg.size() < DEPTH);
        psel       = pv && (pr != 0);
        head_write = 1'b0;
        hr         = '0;
        hd         = '0;
        if (mq_reg.size() > 0) begin
            hr = mq_reg[0];
            hd = mq_data[0];
            if (hr == 0 || !psel || hr == pr) begin
                void'(mq_reg.pop_front());
                void'(mq_data.pop_front());
                head_write = (hr != 0) && !psel;
            end
        end
        if (psel) begin
            exp_w = 1'b1; exp_wreg = pr; exp_wdata = pd;
        end else if (head_write) begin
            exp_w = 1'b1; exp_wreg = hr; exp_wdata = hd;
        end else begin
            exp_w = 1'b0;
        end
        if (mv && ready) begin
            mq_reg.push_back(mr);
            mq_data.push_back(md);
        end
        #1;
        chk("w", w, exp_w);
        chk("W_Reg", W_Reg, exp_wreg);
        chk("W_Data", W_Data, exp_wdata);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
    endtask

    // Assert reset mid-cycle with live state, check immediate effect, release
    task automatic reset_mid();
        #2 rst = 1'b0;
        #1;
        chk("rst_w", w, 1'b0);
        chk("rst_wreg", W_Reg, '0);
        chk("rst_wdata", W_Data, '0);
        chk("rst_pending", pending, 1'b0);
        chk("rst_chk_hit", chk_hit, 1'b0);
        chk("rst_ready", mdu_ready, 1'b1);
        mq_reg.delete();
        mq_data.delete();
        exp_w = 1'b0; exp_wreg = '0; exp_wdata = '0;
        @(posedge clk);
        #1;
        chk("rst_hold_w", w, 1'b0);
        chk("rst_hold_pending", pending, 1'b0);
        #2 rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        pipe_valid = 1'b0; pipe_reg = '0; pipe_data = '0;
        mdu_valid = 1'b0; mdu_reg = '0; mdu_data = '0; chk_reg = '0;
        exp_w = 1'b0; exp_wreg = '0; exp_wdata = '0;
        #2;
        chk("reset_w", w, 1'b0);
        chk("reset_wreg", W_Reg, '0);
        chk("reset_wdata", W_Data, '0);
        chk("reset_ready", mdu_ready, 1'b1);
        chk("reset_pending", pending, 1'b0);
        chk("reset_chk_hit", chk_hit, 1'b0);
        @(posedge clk);
        #3 rst = 1'b1;

        // Pipeline-only writeback, and pipeline write to register 0
        cycle(1'b1, 5'd5, 32'h1234, 1'b0, '0, '0, '0);
        chk("pipe_w", w, 1'b1);
        chk("pipe_reg", W_Reg, 5'd5);
        chk("pipe_data", W_Data, 32'h1234);
        cycle(1'b1, 5'd0, 32'hDEAD, 1'b0, '0, '0, '0);
        chk("pipe_r0_w", w, 1'b0);
        chk("pipe_r0_hold", W_Reg, 5'd5);

        // Pipeline priority over a buffered result
        cycle(1'b0, '0, '0, 1'b1, 5'd7, 32'hAA, '0);
        chk("prio_push_w", w, 1'b0);
        cycle(1'b1, 5'd3, 32'h301, 1'b0, '0, '0, '0);
        chk("prio_c3", W_Reg, 5'd3);
        cycle(1'b1, 5'd3, 32'h302, 1'b0, '0, '0, '0);
        chk("prio_c4", W_Reg, 5'd3);
        chk("prio_pending", pending, 1'b1);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
        chk("prio_head_reg", W_Reg, 5'd7);
        chk("prio_head_data", W_Data, 32'hAA);
        chk("prio_drained", pending, 1'b0);
        idle(2);

        // Full buffer back-pressure and in-order drain
        cycle(1'b1, 5'd5, 32'h500, 1'b1, 5'd1, 32'h11, '0);
        cycle(1'b1, 5'd5, 32'h501, 1'b1, 5'd2, 32'h22, '0);
        chk("full_ready", mdu_ready, 1'b0);
        cycle(1'b1, 5'd5, 32'h502, 1'b1, 5'd3, 32'h33, '0);
        cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'h33, '0);
        chk("full_first_reg", W_Reg, 5'd1);
        chk("full_first_data", W_Data, 32'h11);
        chk("full_ready_back", mdu_ready, 1'b1);
        cycle(1'b0, '0, '0, 1'b1, 5'd3, 32'h33, '0);
        chk("full_second_reg", W_Reg, 5'd2);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
        chk("full_third_reg", W_Reg, 5'd3);
        chk("full_third_data", W_Data, 32'h33);
        idle(2);

        // Same-register conflict and register-0 head
        cycle(1'b1, 5'd6, 32'h600, 1'b1, 5'd4, 32'h44, '0);
        cycle(1'b1, 5'd4, 32'h99, 1'b0, '0, '0, '0);
        chk("conflict_data", W_Data, 32'h99);
        chk("conflict_dropped", pending, 1'b0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
        chk("conflict_single", w, 1'b0);
        cycle(1'b1, 5'd6, 32'h601, 1'b1, 5'd0, 32'h55, '0);
        cycle(1'b1, 5'd6, 32'h602, 1'b0, '0, '0, '0);
        chk("zero_head_popped", pending, 1'b0);
        cycle(1'b0, '0, '0, 1'b1, 5'd0, 32'h56, '0);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, '0);
        chk("zero_head_nowrite", w, 1'b0);
        idle(1);

        // Hazard lookup
        cycle(1'b1, 5'd1, 32'h100, 1'b1, 5'd9, 32'hAB, 5'd9);
        chk_reg = 5'd8; #1;
        chk("hit_r8", chk_hit, 1'b0);
        chk_reg = 5'd0; #1;
        chk("hit_r0", chk_hit, 1'b0);
        cycle(1'b1, 5'd1, 32'h101, 1'b0, '0, '0, 5'd9);
        cycle(1'b0, '0, '0, 1'b0, '0, '0, 5'd9);
        chk("hit_after_pop", chk_hit, 1'b0);
        idle(1);

        // Reset with two entries buffered
        cycle(1'b1, 5'd1, 32'h102, 1'b1, 5'd10, 32'hA0, 5'd10);
        cycle(1'b1, 5'd1, 32'h103, 1'b1, 5'd11, 32'hB0, 5'd10);
        chk("pre_rst_hit", chk_hit, 1'b1);
        reset_mid();
        idle(4);

        // Random traffic with a small register range to provoke conflicts
        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_mid();
            cycle(1'($urandom_range(0, 1)), A'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 2) != 0), A'($urandom_range(0, 7)), $urandom,
                  A'($urandom_range(0, 7)));
        end
        idle(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter W, default 32 (`WORD_LEN), data word width.
REQ-002 SHALL have parameter A, default 5 (`REGADDR_LEN), register address width.
REQ-003 SHALL have parameter DEPTH, default 2, long-latency buffer entries (power of two, >=2).
REQ-004 SHALL use one clock; reset is asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  asynchronous active-low reset.
REQ-007 pipe_valid  in  1  MEM/WB stage has a writeback this cycle.
REQ-008 pipe_reg  in  A  pipeline destination register.
REQ-009 pipe_data  in  W  pipeline result.
REQ-010 mdu_valid  in  1  long-latency unit offers a result.
REQ-011 mdu_ready  out  1  buffer can accept (count < DEPTH).
REQ-012 mdu_reg  in  A  long-latency destination register.
REQ-013 mdu_data  in  W  long-latency result.
REQ-014 chk_reg  in  A  decode-stage source register to check.
REQ-015 chk_hit  out  1  some buffered entry targets chk_reg (combinational).
REQ-016 w  out  1  regfile write enable, registered.
REQ-017 W_Reg  out  A  regfile write address, registered.
REQ-018 W_Data  out  W  regfile write data, registered.
REQ-019 pending  out  1  buffer non-empty.

Function
REQ-020 SHALL keep an in-order FIFO of DEPTH {reg, data} entries with wrap-around read/write pointers and a 0..DEPTH count.
REQ-021 SHALL push on the rising edge when mdu_valid && mdu_ready; mdu_valid with mdu_ready=0 changes no state.
REQ-022 mdu_ready SHALL depend only on registered count (no same-cycle pass-through when full, even if a pop occurs).
REQ-023 Pipeline write: pipe_valid && pipe_reg!=0 at edge N SHALL give w=1, W_Reg=pipe_reg, W_Data=pipe_data during cycle N+1.
REQ-024 Pipeline SHALL have absolute priority; the FIFO head SHALL pop and write only when no pipeline write is selected at that edge.
REQ-025 A FIFO head targeting register 0 SHALL pop at the next edge regardless of the pipeline, with w=0 for it.
REQ-026 If a pipeline write and the FIFO head target the same nonzero register at the same edge, the head SHALL pop without writing (pipeline write supersedes).
REQ-027 An entry pushed at edge N SHALL not pop before edge N+1 (earliest w=1 in cycle N+2).
REQ-028 Simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-029 When nothing is selected at an edge, w SHALL be 0; W_Reg and W_Data SHALL hold previous values.
REQ-030 Writes to register 0 SHALL never produce w=1.
REQ-031 chk_hit SHALL be 1 iff chk_reg!=0 and a valid entry has reg==chk_reg; the head popping this cycle still counts.
REQ-032 pending SHALL equal (count!=0).

Reset
REQ-033 rst=0 SHALL immediately force w=0, W_Reg=0, W_Data=0, count=0, pointers=0, mdu_ready=1, pending=0, chk_hit=0.
REQ-034 Reset mid-operation SHALL discard all buffered entries with no write; first push is accepted at the first edge after rst rises.

Verification
REQ-035 Pipe-only: pipe_valid=1, reg=5, data=0x1234 at edge 1 -> cycle 2 w=1, W_Reg=5, W_Data=0x1234; pipe_reg=0 -> w=0.
REQ-036 Priority: push {7,0xAA} at edge 1; pipe writes reg 3 at edges 2,3, idle at edge 4 -> w reg 3 in cycles 3,4; W_Reg=7, W_Data=0xAA in cycle 5; pending 1->0 after edge 4.
REQ-037 Full: pipe busy, push {1,0x11},{2,0x22} -> mdu_ready=0, third offer {3,0x33} held off; pipe idles -> writes reg 1 then reg 2 in order, mdu_ready returns 1 after first pop.
REQ-038 Conflict/zero: head {4,0x44} with pipe {4,0x99} at same edge -> single write 0x99, head dropped; head {0,0x55} -> popped, w=0.
REQ-039 chk_hit: buffer holds {9,x}, chk_reg=9 -> 1; chk_reg=0 or 8 -> 0; after pop of reg 9 -> 0.
REQ-040 Reset mid-run: two entries buffered, rst=0 mid-cycle -> w, pending, chk_hit drop immediately; after release no stale write ever appears.
